// File: rtl/wav_header_parser.sv
// Passive RIFF/WAVE header parser that snoops the ioctl download stream feeding the wave ROM.
// Reports the PCM fmt fields plus the data chunk start/length for the wave DMA; never touches the write path.
module wav_header_parser #(
  parameter int         ROM_AW    = 17,
  parameter logic [7:0] WAV_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        busy,
  output logic        hdr_valid,
  output logic        hdr_error,
  output logic [2:0]  err_code,
  output logic [15:0] num_channels,
  output logic [31:0] sample_rate,
  output logic [15:0] bits_per_sample,
  output logic [24:0] data_start,
  output logic [31:0] data_len,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RIFF   = 4'd1,
    S_WAVE   = 4'd2,
    S_CHK_ID = 4'd3,
    S_CHK_SZ = 4'd4,
    S_FMT    = 4'd5,
    S_SKIP   = 4'd6,
    S_DONE   = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam logic [2:0] ERR_BAD_RIFF  = 3'd1;
  localparam logic [2:0] ERR_BAD_WAVE  = 3'd2;
  localparam logic [2:0] ERR_NOT_PCM   = 3'd3;
  localparam logic [2:0] ERR_NO_FMT    = 3'd4;
  localparam logic [2:0] ERR_NO_DATA   = 3'd5;
  localparam logic [2:0] ERR_ADDR_SKIP = 3'd6;

  // Chunk IDs packed little-endian: first byte of the tag sits in bits [7:0].
  localparam logic [31:0] ID_RIFF = 32'h4646_4952;
  localparam logic [31:0] ID_WAVE = 32'h4556_4157;
  localparam logic [31:0] ID_FMT  = 32'h2074_6d66;
  localparam logic [31:0] ID_DATA = 32'h6174_6164;

  localparam logic [32:0] ROM_BYTES = 33'd1 << ROM_AW;

  function automatic logic [7:0] id_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  logic        dl_q, dl_d;
  logic        busy_q, busy_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        hdr_error_q, hdr_error_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [2:0]  err_lat_q, err_lat_d;
  logic [15:0] num_ch_q, num_ch_d;
  logic [31:0] rate_q, rate_d;
  logic [15:0] bits_q, bits_d;
  logic [24:0] ds_q, ds_d;
  logic [31:0] len_q, len_d;
  logic [24:0] exp_q, exp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] id_q, id_d;
  logic [23:0] size_q, size_d;
  logic [31:0] remain_q, remain_d;
  logic        pad_q, pad_d;
  logic [4:0]  fmt_off_q, fmt_off_d;
  logic [7:0]  tag_lo_q, tag_lo_d;
  logic        fmt_seen_q, fmt_seen_d;

  logic        start, fin, accept, parsing, do_err;
  logic [2:0]  err_val;
  state_t      st;
  logic [24:0] ex;
  logic [31:0] full_size;
  logic [24:0] ds_next;
  logic [32:0] room;

  // Handshake: a byte is taken when ioctl_download & ioctl_wr while a parse is active
  // (or in the start cycle itself); the stream has no ready, so every strobe must be absorbed.
  always_comb begin
    state_d     = state_q;
    dl_d        = ioctl_download;
    busy_d      = busy_q;
    hdr_valid_d = hdr_valid_q;
    hdr_error_d = hdr_error_q;
    err_code_d  = err_code_q;
    err_lat_d   = err_lat_q;
    num_ch_d    = num_ch_q;
    rate_d      = rate_q;
    bits_d      = bits_q;
    ds_d        = ds_q;
    len_d       = len_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    size_d      = size_q;
    remain_d    = remain_q;
    pad_d       = pad_q;
    fmt_off_d   = fmt_off_q;
    tag_lo_d    = tag_lo_q;
    fmt_seen_d  = fmt_seen_q;
    do_err      = 1'b0;
    err_val     = 3'd0;

    start   = ioctl_download & ~dl_q & (ioctl_index == WAV_INDEX);
    fin     = dl_q & ~ioctl_download & busy_q;
    accept  = ioctl_download & ioctl_wr & (busy_q | start);
    st      = start ? S_RIFF : state_q;
    ex      = start ? 25'd0 : exp_q;
    parsing = (st != S_IDLE) && (st != S_DONE) && (st != S_ERROR);

    full_size = {ioctl_dout, size_q};
    ds_next   = ex + 25'd1;
    room      = ({8'd0, ds_next} >= ROM_BYTES) ? 33'd0 : ROM_BYTES - {8'd0, ds_next};

    if (start) begin
      busy_d      = 1'b1;
      hdr_valid_d = 1'b0;
      hdr_error_d = 1'b0;
      err_code_d  = 3'd0;
      err_lat_d   = 3'd0;
      num_ch_d    = 16'd0;
      rate_d      = 32'd0;
      bits_d      = 16'd0;
      ds_d        = 25'd0;
      len_d       = 32'd0;
      exp_d       = 25'd0;
      cnt_d       = 2'd0;
      remain_d    = 32'd0;
      pad_d       = 1'b0;
      fmt_off_d   = 5'd0;
      fmt_seen_d  = 1'b0;
      state_d     = S_RIFF;
    end

    if (accept && parsing) begin
      if (ioctl_addr != ex) begin
        do_err  = 1'b1;
        err_val = ERR_ADDR_SKIP;
      end else begin
        exp_d = ex + 25'd1;
        case (st)
          S_RIFF: begin
            if (!ex[2] && ioctl_dout != id_byte(ID_RIFF, ex[1:0])) begin
              do_err  = 1'b1;
              err_val = ERR_BAD_RIFF;
            end
            if (ex[2:0] == 3'd7) state_d = S_WAVE;
          end
          S_WAVE: begin
            if (ioctl_dout != id_byte(ID_WAVE, ex[1:0])) begin
              do_err  = 1'b1;
              err_val = ERR_BAD_WAVE;
            end
            if (ex[1:0] == 2'd3) begin
              state_d = S_CHK_ID;
              cnt_d   = 2'd0;
            end
          end
          S_CHK_ID: begin
            case (cnt_q)
              2'd0:    id_d[7:0]   = ioctl_dout;
              2'd1:    id_d[15:8]  = ioctl_dout;
              2'd2:    id_d[23:16] = ioctl_dout;
              default: id_d[31:24] = ioctl_dout;
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = S_CHK_SZ;
          end
          S_CHK_SZ: begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0: size_d[7:0]   = ioctl_dout;
              2'd1: size_d[15:8]  = ioctl_dout;
              2'd2: size_d[23:16] = ioctl_dout;
              default: begin
                if (id_q == ID_DATA) begin
                  if (!fmt_seen_q) begin
                    do_err  = 1'b1;
                    err_val = ERR_NO_FMT;
                  end else begin
                    ds_d    = ds_next;
                    len_d   = ({1'b0, full_size} > room) ? room[31:0] : full_size;
                    state_d = S_DONE;
                  end
                end else begin
                  remain_d  = full_size;
                  pad_d     = full_size[0];
                  fmt_off_d = 5'd0;
                  if (full_size == 32'd0) state_d = S_CHK_ID;
                  else if (id_q == ID_FMT) state_d = S_FMT;
                  else state_d = S_SKIP;
                end
              end
            endcase
          end
          S_FMT, S_SKIP: begin
            if (remain_q != 32'd0) begin
              remain_d = remain_q - 32'd1;
              if (remain_q == 32'd1 && !pad_q) begin
                state_d = S_CHK_ID;
                cnt_d   = 2'd0;
              end
              if (st == S_FMT) begin
                fmt_off_d = (fmt_off_q == 5'd16) ? fmt_off_q : fmt_off_q + 5'd1;
                case (fmt_off_q)
                  5'd0: tag_lo_d = ioctl_dout;
                  5'd1: begin
                    if ({ioctl_dout, tag_lo_q} != 16'd1) begin
                      do_err  = 1'b1;
                      err_val = ERR_NOT_PCM;
                    end
                  end
                  5'd2:  num_ch_d[7:0]     = ioctl_dout;
                  5'd3:  num_ch_d[15:8]    = ioctl_dout;
                  5'd4:  rate_d[7:0]       = ioctl_dout;
                  5'd5:  rate_d[15:8]      = ioctl_dout;
                  5'd6:  rate_d[23:16]     = ioctl_dout;
                  5'd7:  rate_d[31:24]     = ioctl_dout;
                  5'd14: bits_d[7:0]       = ioctl_dout;
                  5'd15: begin
                    bits_d[15:8] = ioctl_dout;
                    fmt_seen_d   = 1'b1;
                  end
                  default: ;
                endcase
              end
            end else begin
              // Word-alignment pad byte after an odd-sized chunk body.
              pad_d   = 1'b0;
              state_d = S_CHK_ID;
              cnt_d   = 2'd0;
            end
          end
          default: ;
        endcase
      end
    end

    if (do_err) begin
      state_d   = S_ERROR;
      err_lat_d = err_val;
    end

    if (fin) begin
      busy_d  = 1'b0;
      state_d = S_IDLE;
      case (state_q)
        S_DONE: hdr_valid_d = 1'b1;
        S_ERROR: begin
          hdr_error_d = 1'b1;
          err_code_d  = err_lat_q;
        end
        default: begin
          hdr_error_d = 1'b1;
          err_code_d  = fmt_seen_q ? ERR_NO_DATA : ERR_NO_FMT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b1;   // a download already running at reset must not look like a rise
      busy_q      <= 1'b0;
      hdr_valid_q <= 1'b0;
      hdr_error_q <= 1'b0;
      err_code_q  <= 3'd0;
      err_lat_q   <= 3'd0;
      num_ch_q    <= 16'd0;
      rate_q      <= 32'd0;
      bits_q      <= 16'd0;
      ds_q        <= 25'd0;
      len_q       <= 32'd0;
      exp_q       <= 25'd0;
      cnt_q       <= 2'd0;
      id_q        <= 32'd0;
      size_q      <= 24'd0;
      remain_q    <= 32'd0;
      pad_q       <= 1'b0;
      fmt_off_q   <= 5'd0;
      tag_lo_q    <= 8'd0;
      fmt_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      busy_q      <= busy_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_error_q <= hdr_error_d;
      err_code_q  <= err_code_d;
      err_lat_q   <= err_lat_d;
      num_ch_q    <= num_ch_d;
      rate_q      <= rate_d;
      bits_q      <= bits_d;
      ds_q        <= ds_d;
      len_q       <= len_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      size_q      <= size_d;
      remain_q    <= remain_d;
      pad_q       <= pad_d;
      fmt_off_q   <= fmt_off_d;
      tag_lo_q    <= tag_lo_d;
      fmt_seen_q  <= fmt_seen_d;
    end
  end

  assign busy            = busy_q;
  assign hdr_valid       = hdr_valid_q;
  assign hdr_error       = hdr_error_q;
  assign err_code        = err_code_q;
  assign num_channels    = num_ch_q;
  assign sample_rate     = rate_q;
  assign bits_per_sample = bits_q;
  assign data_start      = ds_q;
  assign data_len        = len_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_wav_header_parser.sv
// Bench for wav_header_parser: WAV images are built in memory, streamed over ioctl,
// and every end-of-download report is checked against a chunk-walking reference model.
module tb_wav_header_parser;

  localparam int ROM_AW = 17;
  localparam int EW     = 126;

  localparam logic [31:0] ID_RIFF = 32'h4646_4952;
  localparam logic [31:0] ID_WAVE = 32'h4556_4157;
  localparam logic [31:0] ID_FMT  = 32'h2074_6d66;
  localparam logic [31:0] ID_DATA = 32'h6174_6164;
  localparam logic [31:0] ID_LIST = 32'h5453_494c;

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        busy, hdr_valid, hdr_error;
  logic [2:0]  err_code;
  logic [15:0] num_channels, bits_per_sample;
  logic [31:0] sample_rate, data_len;
  logic [24:0] data_start;
  logic [3:0]  dbg_state;

  always #5 clk_sys = ~clk_sys;

  wav_header_parser #(.ROM_AW(ROM_AW), .WAV_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .busy(busy), .hdr_valid(hdr_valid), .hdr_error(hdr_error), .err_code(err_code),
    .num_channels(num_channels), .sample_rate(sample_rate), .bits_per_sample(bits_per_sample),
    .data_start(data_start), .data_len(data_len), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    file_mem [0:1023];
  int            file_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic v, input logic e, input logic [2:0] c,
                                       input logic [15:0] ch, input logic [31:0] rate,
                                       input logic [15:0] bits, input logic [24:0] ds,
                                       input logic [31:0] len);
    return {v, e, c, ch, rate, bits, ds, len};
  endfunction

  function automatic logic [EW-1:0] mk_err(input logic [2:0] c);
    return mk(1'b0, 1'b1, c, 16'd0, 32'd0, 16'd0, 25'd0, 32'd0);
  endfunction

  // ---------------- file image builder ----------------
  task automatic put8(input int a, input logic [7:0] v);
    file_mem[a] = v;
  endtask

  task automatic put32(input int a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) file_mem[a+k] = v[8*k +: 8];
  endtask

  task automatic build(input int ch, input logic [31:0] rate, input int bits, input int fmt_size,
                       input int tag, input bit has_list, input logic [31:0] list_size,
                       input logic [31:0] data_size, input int n_data, input bit data_first);
    int p;
    int body;
    put32(0, ID_RIFF);
    put32(4, $urandom);
    put32(8, ID_WAVE);
    p = 12;
    if (data_first) begin
      put32(p, ID_DATA); put32(p + 4, data_size); p += 8;
    end
    put32(p, ID_FMT); put32(p + 4, 32'(fmt_size)); p += 8;
    for (int k = 0; k < fmt_size + (fmt_size % 2); k++) put8(p + k, 8'($urandom));
    put8(p, 8'(tag)); put8(p + 1, 8'(tag >> 8));
    put8(p + 2, 8'(ch)); put8(p + 3, 8'(ch >> 8));
    put32(p + 4, rate);
    put8(p + 14, 8'(bits)); put8(p + 15, 8'(bits >> 8));
    p += fmt_size + (fmt_size % 2);
    if (has_list) begin
      put32(p, ID_LIST); put32(p + 4, list_size); p += 8;
      body = (list_size > 32'd40) ? 40 : int'(list_size) + int'(list_size[0]);
      for (int k = 0; k < body; k++) put8(p + k, 8'($urandom));
      p += body;
    end
    if (!data_first) begin
      put32(p, ID_DATA); put32(p + 4, data_size); p += 8;
      for (int k = 0; k < n_data; k++) put8(p + k, 8'($urandom));
      p += n_data;
    end
    file_len = p;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rd32(input longint a);
    return {file_mem[int'(a)+3], file_mem[int'(a)+2], file_mem[int'(a)+1], file_mem[int'(a)]};
  endfunction

  function automatic logic [15:0] rd16(input longint a);
    return {file_mem[int'(a)+1], file_mem[int'(a)]};
  endfunction

  // Walks the image chunk by chunk; only the first 'avail' bytes are ever seen as accepted.
  function automatic logic [EW-1:0] model(input int avail, input bit has_skip);
    longint p, room, sz;
    logic [31:0] id, size, rate;
    logic [15:0] ch, bits;
    bit fmt_seen;
    fmt_seen = 0; ch = 0; bits = 0; rate = 0;
    for (int i = 0; i < 12; i++) begin
      if (i >= avail) return has_skip ? mk_err(3'd6) : mk_err(3'd4);
      if (i < 4 && file_mem[i] != ID_RIFF[8*i +: 8]) return mk_err(3'd1);
      if (i >= 8 && file_mem[i] != ID_WAVE[8*(i-8) +: 8]) return mk_err(3'd2);
    end
    p = 12;
    forever begin
      if (p + 8 > avail) return has_skip ? mk_err(3'd6) : mk_err(fmt_seen ? 3'd5 : 3'd4);
      id = rd32(p); size = rd32(p + 4); p += 8;
      if (id == ID_DATA) begin
        if (!fmt_seen) return mk_err(3'd4);
        room = (p >= (longint'(1) << ROM_AW)) ? 0 : (longint'(1) << ROM_AW) - p;
        sz   = size;
        return mk(1'b1, 1'b0, 3'd0, ch, rate, bits, 25'(p), 32'((sz > room) ? room : sz));
      end
      if (id == ID_FMT) begin
        if (size >= 2 && p + 1 < avail && rd16(p) != 16'd1) return mk_err(3'd3);
        if (size >= 16 && p + 15 < avail) begin
          fmt_seen = 1;
          ch = rd16(p + 2); rate = rd32(p + 4); bits = rd16(p + 14);
        end
      end
      p += longint'(size) + longint'(size[0]);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic download(input logic [7:0] idx, input int n, input int skip_at, input int reset_at);
    int addr;
    int gap;
    addr = 0;
    @(posedge clk_sys); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == skip_at) addr++;
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(addr);
      ioctl_dout = file_mem[i];
      if (i == reset_at) reset = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      reset    = 1'b0;
      if (i == reset_at) begin
        chk("busy_after_reset", 64'(busy), 64'd0);
        chk("valid_after_reset", 64'({hdr_valid, hdr_error}), 64'd0);
      end
      if (i == 0 && idx != 8'd0) chk("busy_wrong_index", 64'(busy), 64'd0);
      addr++;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk_sys); #1; end
    end
    ioctl_download = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin @(posedge clk_sys); t++; end
    if (exp_q.size() != 0) begin
      chk("report_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic          rep_prev = 1'b0;
  logic [EW-1:0] e;
  always @(negedge clk_sys) begin
    if (reset) begin
      rep_prev = 1'b0;
    end else begin
      if ((hdr_valid | hdr_error) && !rep_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_report", 64'({hdr_valid, hdr_error}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("hdr_valid", 64'(hdr_valid), 64'(e[125]));
          chk("hdr_error", 64'(hdr_error), 64'(e[124]));
          chk("busy_at_report", 64'(busy), 64'd0);
          if (e[124]) chk("err_code", 64'(err_code), 64'(e[123:121]));
          if (e[125]) begin
            chk("num_channels", 64'(num_channels), 64'(e[120:105]));
            chk("sample_rate", 64'(sample_rate), 64'(e[104:73]));
            chk("bits_per_sample", 64'(bits_per_sample), 64'(e[72:57]));
          end
          chk("data_start", 64'(data_start), 64'(e[56:32]));
          chk("data_len", 64'(data_len), 64'(e[31:0]));
        end
      end
      rep_prev = hdr_valid | hdr_error;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ch, bits, fmt_size, tag, n, skip, pos, sel;
    logic [31:0] rate, dsz, lsz;
    bit has_list, dfirst;
    logic [7:0] idx;

    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(posedge clk_sys); #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_flags", 64'({hdr_valid, hdr_error, err_code}), 64'd0);
    chk("reset_fields", 64'(num_channels) | 64'(sample_rate) | 64'(bits_per_sample), 64'd0);
    chk("reset_data", 64'(data_start) | 64'(data_len), 64'd0);

    // canonical 44-byte header
    build(1, 22050, 8, 16, 1, 0, 0, 32'h4000, 4, 0);
    exp_q.push_back(mk(1, 0, 0, 16'd1, 32'd22050, 16'd8, 25'd44, 32'h4000));
    download(8'd0, file_len, -1, -1); drain();

    // LIST chunk of odd size 5 before data
    build(1, 22050, 8, 16, 1, 1, 5, 32'h4000, 2, 0);
    exp_q.push_back(mk(1, 0, 0, 16'd1, 32'd22050, 16'd8, 25'd58, 32'h4000));
    download(8'd0, file_len, -1, -1); drain();

    // float format tag
    build(2, 44100, 32, 16, 3, 0, 0, 32'h100, 0, 0);
    exp_q.push_back(mk_err(3'd3));
    download(8'd0, file_len, -1, -1); drain();

    // RIFX magic
    build(1, 22050, 8, 16, 1, 0, 0, 32'h4000, 0, 0);
    file_mem[3] = 8'h58;
    exp_q.push_back(mk_err(3'd1));
    download(8'd0, file_len, -1, -1); drain();

    // huge data size clamped to ROM space
    build(1, 22050, 8, 16, 1, 0, 0, 32'hFFFF_FFFF, 3, 0);
    exp_q.push_back(mk(1, 0, 0, 16'd1, 32'd22050, 16'd8, 25'd44, 32'd131028));
    download(8'd0, file_len, -1, -1); drain();

    // file ends inside LIST
    build(1, 22050, 8, 16, 1, 1, 100, 32'h4000, 0, 0);
    exp_q.push_back(mk_err(3'd5));
    download(8'd0, 64, -1, -1); drain();

    // address jump 20 -> 22
    build(1, 22050, 8, 16, 1, 0, 0, 32'h4000, 0, 0);
    exp_q.push_back(mk_err(3'd6));
    download(8'd0, file_len, 21, -1); drain();

    // data chunk before fmt
    build(1, 22050, 8, 16, 1, 0, 0, 32'h4000, 0, 1);
    exp_q.push_back(mk_err(3'd4));
    download(8'd0, file_len, -1, -1); drain();

    // reset at byte 30, then a fresh download: only the second reports
    build(1, 22050, 8, 16, 1, 0, 0, 32'h4000, 4, 0);
    download(8'd0, file_len, -1, 30); drain();
    chk("no_report_after_reset", 64'({hdr_valid, hdr_error}), 64'd0);
    exp_q.push_back(mk(1, 0, 0, 16'd1, 32'd22050, 16'd8, 25'd44, 32'h4000));
    download(8'd0, file_len, -1, -1); drain();

    // randomized images against the model
    for (int it = 0; it < 40; it++) begin
      ch       = $urandom_range(1, 8);
      bits     = $urandom_range(1, 32);
      rate     = $urandom;
      sel      = $urandom_range(0, 3);
      fmt_size = (sel == 0) ? 16 : (sel == 1) ? 17 : (sel == 2) ? 18 : 20;
      tag      = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : 1;
      has_list = ($urandom_range(0, 1) == 1);
      lsz      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 9));
      sel      = $urandom_range(0, 5);
      dsz      = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'd0 : 32'($urandom_range(0, 200000));
      dfirst   = ($urandom_range(0, 19) == 0);
      build(ch, rate, bits, fmt_size, tag, has_list, lsz, dsz, $urandom_range(0, 4), dfirst);
      if ($urandom_range(0, 19) == 0) begin
        pos = $urandom_range(0, 11);
        file_mem[pos] = file_mem[pos] ^ 8'($urandom_range(1, 255));
      end
      n = file_len;
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, file_len - 1);
      skip = -1;
      if (n > 1 && $urandom_range(0, 9) == 0) skip = $urandom_range(1, n - 1);
      idx = ($urandom_range(0, 19) == 0) ? 8'd7 : 8'd0;
      if (idx == 8'd0) exp_q.push_back(model((skip >= 0) ? skip : n, skip >= 0));
      download(idx, n, skip, -1);
      drain();
    end

    repeat (5) @(posedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
